// File: rtl/shift_alu_pipe.sv
// shift_alu_pipe: two-stage pipelined shifter followed by an ALU.
//   Stage 1 shifts operand m (LSL/LSR/ASR/ROR/RRX) and latches the shifter
//   carry. Stage 2 performs ADD-with-carry/SUB/MOV/CMP against n and
//   registers the result together with the NZCV flags.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready input handshake; in_ready = !out_valid || out_ready
//   op, s_type, shamt ALU operation, shift type, shift amount
//   m, n, carry_in    shifted operand, first ALU operand, current C flag
//   out_valid/out_ready output handshake
//   d, carry_out, overflow, zero, negative, write_en  registered result
module shift_alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [1:0]         s_type,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   n,
    input  logic               carry_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   d,
    output logic               carry_out,
    output logic               overflow,
    output logic               zero,
    output logic               negative,
    output logic               write_en
);

    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MOV = 2'b10, OP_CMP = 2'b11} op_t;
    typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_t;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: shifter ----------------
    logic [WIDTH-1:0]   sh;
    logic               sc;
    logic [WIDTH:0]     ext;
    logic [2*WIDTH-1:0] rot;

    // The one-bit extension of ext catches the last bit shifted out, which
    // is the shifter carry for LSL/LSR/ASR.
    always_comb begin
        sh  = m;
        sc  = carry_in;
        ext = '0;
        rot = '0;
        case (shift_t'(s_type))
            SH_LSL: begin
                if (shamt != '0) begin
                    ext = {1'b0, m} << shamt;
                    sh  = ext[WIDTH-1:0];
                    sc  = ext[WIDTH];
                end
            end
            SH_LSR: begin
                if (shamt == '0) begin
                    sh = '0;
                    sc = m[WIDTH-1];
                end else begin
                    ext = {m, 1'b0} >> shamt;
                    sh  = ext[WIDTH:1];
                    sc  = ext[0];
                end
            end
            SH_ASR: begin
                if (shamt == '0) begin
                    sh = {WIDTH{m[WIDTH-1]}};
                    sc = m[WIDTH-1];
                end else begin
                    ext = $signed({m, 1'b0}) >>> shamt;
                    sh  = ext[WIDTH:1];
                    sc  = ext[0];
                end
            end
            SH_ROR: begin
                if (shamt == '0) begin
                    sh = {carry_in, m[WIDTH-1:1]};
                    sc = m[0];
                end else begin
                    rot = {m, m} >> shamt;
                    sh  = rot[WIDTH-1:0];
                    sc  = rot[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

    logic             s1_valid;
    op_t              s1_op;
    logic [WIDTH-1:0] s1_sh;
    logic             s1_sc;
    logic             s1_cin;
    logic [WIDTH-1:0] s1_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_sh    <= '0;
            s1_sc    <= 1'b0;
            s1_cin   <= 1'b0;
            s1_n     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_op    <= op_t'(op);
            s1_sh    <= sh;
            s1_sc    <= sc;
            s1_cin   <= carry_in;
            s1_n     <= n;
        end
    end

    // ---------------- stage 2: ALU ----------------
    logic             is_sub;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_d;
    logic             alu_c;
    logic             alu_v;

    always_comb begin
        is_sub = (s1_op == OP_SUB) || (s1_op == OP_CMP);
        b      = is_sub ? ~s1_sh : s1_sh;
        ci     = is_sub ? 1'b1 : s1_cin;
        sum    = {1'b0, s1_n} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        alu_d  = sum[WIDTH-1:0];
        alu_c  = sum[WIDTH];
        alu_v  = (s1_n[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != s1_n[WIDTH-1]);
        if (s1_op == OP_MOV) begin
            alu_d = s1_sh;
            alu_c = s1_sc;
            alu_v = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            write_en  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            d         <= alu_d;
            carry_out <= alu_c;
            overflow  <= alu_v;
            zero      <= (alu_d == '0);
            negative  <= alu_d[WIDTH-1];
            write_en  <= (s1_op != OP_CMP);
        end
    end

endmodule

// File: tb/tb_shift_alu_pipe.sv
// Testbench for shift_alu_pipe: directed vectors pinned to literal results,
// backpressure and asynchronous-reset scenarios, then randomized traffic,
// all scored against a behavioural model.
module tb_shift_alu_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [1:0]   s_type;
    logic [4:0]   shamt;
    logic [W-1:0] m;
    logic [W-1:0] n;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         carry_out, overflow, zero, negative, write_en;

    int tests = 0;
    int fails = 0;

    shift_alu_pipe #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .s_type(s_type), .shamt(shamt), .m(m), .n(n),
        .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .carry_out(carry_out), .overflow(overflow), .zero(zero),
        .negative(negative), .write_en(write_en)
    );

    always #5 clk = ~clk;

    // packed result: {write_en, N, Z, C, V, d}
    logic [W+4:0] dut_out;
    assign dut_out = {write_en, negative, zero, carry_out, overflow, d};

    function automatic logic [W+4:0] pk(logic we, logic nf, logic zf, logic cf, logic vf, logic [W-1:0] dv);
        return {we, nf, zf, cf, vf, dv};
    endfunction

    // Behavioural reference computed from the architectural rules.
    function automatic logic [W+4:0] model(logic [1:0] o, logic [1:0] st, logic [4:0] sa,
                                           logic [W-1:0] mm, logic [W-1:0] nn, logic cin);
        int s = int'(sa);
        logic [W-1:0] shv;
        logic sc;
        logic [W-1:0] dv;
        logic cf, vf;
        longint unsigned ufull;
        longint sres;
        case (st)
            2'd0: if (s == 0) begin shv = mm; sc = cin; end
                  else begin shv = mm << s; sc = mm[W-s]; end
            2'd1: if (s == 0) begin shv = '0; sc = mm[W-1]; end
                  else begin shv = mm >> s; sc = mm[s-1]; end
            2'd2: if (s == 0) begin shv = {W{mm[W-1]}}; sc = mm[W-1]; end
                  else begin shv = W'($signed(mm) >>> s); sc = mm[s-1]; end
            default: if (s == 0) begin shv = {cin, mm[W-1:1]}; sc = mm[0]; end
                  else begin shv = (mm >> s) | (mm << (W - s)); sc = mm[s-1]; end
        endcase
        case (o)
            2'd0: begin
                ufull = longint'(nn) + longint'(shv) + longint'(cin);
                dv    = ufull[W-1:0];
                cf    = ufull[W];
                sres  = longint'($signed(nn)) + longint'($signed(shv)) + longint'(cin);
                vf    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            2'd2: begin dv = shv; cf = sc; vf = 1'b0; end
            default: begin
                dv   = nn - shv;
                cf   = (nn >= shv);
                sres = longint'($signed(nn)) - longint'($signed(shv));
                vf   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
        endcase
        return pk(o != 2'd3, dv[W-1], dv == '0, cf, vf, dv);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: expected results queued on accept, checked in order.
    logic [W+4:0] exp_q[$];
    logic [W+4:0] prev_out;
    bit           prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid) begin
                if (prev_stall) chk("stall_hold", 64'(dut_out), 64'(prev_out));
                if (exp_q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                else begin
                    chk("result", 64'(dut_out), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = dut_out;
            if (in_valid && in_ready) exp_q.push_back(model(op, s_type, shamt, m, n, carry_in));
        end
    end

    task automatic drive(logic [1:0] o, logic [1:0] st, logic [4:0] sa,
                         logic [W-1:0] mm, logic [W-1:0] nn, logic cin);
        in_valid = 1'b1; op = o; s_type = st; shamt = sa; m = mm; n = nn; carry_in = cin;
    endtask

    task automatic run_one(string nm, logic [1:0] o, logic [1:0] st, logic [4:0] sa,
                           logic [W-1:0] mm, logic [W-1:0] nn, logic cin, logic [W+4:0] exp);
        chk({nm, "_model"}, 64'(model(o, st, sa, mm, nn, cin)), 64'(exp));
        @(posedge clk); #1;
        drive(o, st, sa, mm, nn, cin);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_not_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_value"}, 64'(dut_out), 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; s_type = '0; shamt = '0; m = '0; n = '0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({out_valid, dut_out}), 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        run_one("lsl4",  2'd2, 2'd0, 5'd4, 32'h1000_000F, 32'h0, 1'b0, pk(1, 0, 0, 1, 0, 32'h0000_00F0));
        run_one("asr0",  2'd2, 2'd2, 5'd0, 32'h8000_0000, 32'h0, 1'b0, pk(1, 1, 0, 1, 0, 32'hFFFF_FFFF));
        run_one("lsr0",  2'd2, 2'd1, 5'd0, 32'h8000_0000, 32'h0, 1'b0, pk(1, 0, 1, 1, 0, 32'h0));
        run_one("rrx",   2'd2, 2'd3, 5'd0, 32'h0000_0003, 32'h0, 1'b1, pk(1, 1, 0, 1, 0, 32'h8000_0001));
        run_one("ror8",  2'd2, 2'd3, 5'd8, 32'h1234_5678, 32'h0, 1'b0, pk(1, 0, 0, 0, 0, 32'h7812_3456));
        run_one("addv",  2'd0, 2'd0, 5'd0, 32'h1, 32'h7FFF_FFFF, 1'b0, pk(1, 1, 0, 0, 1, 32'h8000_0000));
        run_one("cmpeq", 2'd3, 2'd0, 5'd0, 32'h5, 32'h5, 1'b0, pk(0, 0, 1, 1, 0, 32'h0));
        run_one("sub_borrow", 2'd1, 2'd0, 5'd0, 32'h6, 32'h5, 1'b0, pk(1, 1, 0, 0, 0, 32'hFFFF_FFFF));

        // Backpressure: stall from the second result onward.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_ready = 1'b0;
            drive(2'd0, 2'(i), 5'(i + 1), $urandom, $urandom, 1'(i));
            if (i < 3) begin @(posedge clk); #1; end
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with both stages occupied.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'd2, 2'd0, 5'd0, 32'hA5A5_0000 + 32'(i), 32'h0, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_full", 64'(out_valid), 64'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_reset", 64'({out_valid, dut_out}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_after_reset", 64'(out_valid), 64'd0);
        end
        run_one("post_reset", 2'd0, 2'd0, 5'd0, 32'h1, 32'h2, 1'b1, pk(1, 0, 0, 0, 0, 32'h4));

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 7);
            if (!(in_valid && !in_ready)) begin
                if ($urandom_range(0, 3) != 0)
                    drive(2'($urandom), 2'($urandom),
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                          ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                          $urandom, 1'($urandom));
                else
                    in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("random_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift_alu_pipe.md
Name: shift_alu_pipe

Overview:
- Parametrised two-stage pipelined shift-then-ALU unit, successor to the fixed 32-bit combinational ALU/shifter pair.
- Stage 1 applies the operand-M shifter: LSL, LSR, ASR, ROR or RRX.
- Stage 2 applies ADD-with-carry, SUB, MOV or CMP against operand N and produces NZCV-style flags.
- Sits between the instruction decoder and the register-file write port; uses a valid/ready handshake so the downstream writeback can stall it.

Parameters:
- WIDTH, 32, datapath width. Must be a power of two, at least 8.
- SHAMT_W, 5, shift-amount width. Must equal log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit accepts the operation this cycle.
- op  input  2  ALU operation: 00 ADD (with carry_in), 01 SUB, 10 MOV, 11 CMP.
- s_type  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX.
- shamt  input  SHAMT_W  shift amount.
- m  input  WIDTH  shifted operand.
- n  input  WIDTH  first ALU operand.
- carry_in  input  1  current C flag.
- out_valid  output  1  result held on the outputs.
- out_ready  input  1  downstream consumes the result.
- d  output  WIDTH  result.
- carry_out, overflow, zero, negative  output  1 each  flags C, V, Z, N.
- write_en  output  1  result is to be written back; 0 for CMP.

Behaviour:
- Reset (asynchronous, active-high): both stage valid bits clear immediately. out_valid=0, d=0, all flags=0, write_en=0. in_ready=1 once rst deasserts.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv. Both stages move together only when adv=1.
  - Accept occurs when in_valid && in_ready.
  - Stage-1 valid loads in_valid&&adv. Stage-2 (output) valid loads stage-1 valid when adv=1.
  - When adv=0 both stages hold all contents.
- Latency: accept at edge k gives out_valid=1 after edge k+1, i.e. 2 cycles. Full throughput: one operation per cycle while out_ready=1.
- Simultaneous output handshake and input accept in the same cycle is legal; no bubble is inserted.
- Bubbles: stage-1 empty while stage 2 is consumed produces out_valid=0 on the next cycle.
- Shifter (stage 1), producing sh and shifter carry sc:
  - LSL, shamt=0: sh=m, sc=carry_in.
  - LSL, shamt=s>0: sh=m<<s, sc=m[WIDTH-s].
  - LSR, shamt=0 (encodes WIDTH): sh=0, sc=m[WIDTH-1].
  - LSR, s>0: logical right shift, sc=m[s-1].
  - ASR, shamt=0 (encodes WIDTH): sh all bits = m[WIDTH-1], sc=m[WIDTH-1].
  - ASR, s>0: sign-filled shift, sc=m[s-1].
  - ROR, shamt=0 is RRX: sh={carry_in, m[WIDTH-1:1]}, sc=m[0].
  - ROR, s>0: rotate right by s, sc=m[s-1].
- ALU (stage 2), computed at WIDTH+1 bits:
  - ADD: d=n+sh+carry_in. C=bit WIDTH. V=signed overflow (operand signs equal, result sign differs).
  - SUB and CMP: d=n+~sh+1. C=1 when no borrow. V=signed overflow of the subtraction. CMP drives write_en=0; all other ops drive write_en=1.
  - MOV: d=sh, C=sc, V=0.
  - All ops: Z=(d==0), N=d[WIDTH-1].
- Outputs are registered and stable while out_valid && !out_ready.
- Content of stages whose valid bit is 0 is don't-care, but d and flags must never change while out_valid=1 and the output is stalled.

Test Plan:
- WIDTH=32, LSL shamt=4, MOV, m=0x1000_000F -> two cycles later d=0x0000_00F0, C=1, Z=0, N=0, write_en=1.
- ASR shamt=0, MOV, m=0x8000_0000 -> d=0xFFFF_FFFF, C=1, N=1. LSR shamt=0, same m -> d=0, C=1, Z=1.
- ROR shamt=0 (RRX), carry_in=1, MOV, m=0x0000_0003 -> d=0x8000_0001, C=1, N=1. ROR shamt=8, m=0x1234_5678 -> d=0x7812_3456, C=0.
- ADD: n=0x7FFF_FFFF, m=1, LSL 0, carry_in=0 -> d=0x8000_0000, V=1, N=1, C=0. CMP: n=5, m=5 -> Z=1, C=1, V=0, write_en=0.
- Backpressure: 4 back-to-back ops with out_ready=0 from the 2nd result onward -> in_ready=0 while stalled, d held steady. On out_ready=1, results emerge in order, none lost or duplicated.
- Assert rst asynchronously while both stages hold valid ops -> out_valid=0 and d=0 before the next edge. After release no stale result appears and the next accepted op has 2-cycle latency.
